// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the oversampling UART receiver:
// FSM state encoding, legal prescale ratios, majority-vote offset.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } rx_state_t;

  localparam int unsigned PRESCALE_8  = 8;
  localparam int unsigned PRESCALE_16 = 16;
  localparam int unsigned PRESCALE_32 = 32;

  // Samples are taken at mid-OFFSET, mid and mid+OFFSET of each bit.
  localparam int unsigned VOTE_OFFSET = 1;

  typedef struct packed {
    logic parity_enable;
    logic parity_type;
    logic two_stop;
  } frame_cfg_t;

  function automatic logic prescale_is_legal(input int unsigned p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit timing for the UART receiver: edge/bit counters and the registered
// 3-sample majority vote taken around the middle of every bit.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx,
  input  logic                  run,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [3:0]            bit_count,
  output logic                  bit_done,
  output logic                  decision,
  output logic                  decision_valid
);

  logic [PRESCALE_W-1:0] edge_count;
  logic [PRESCALE_W-1:0] mid;
  logic [PRESCALE_W-1:0] last;
  logic [1:0]            early;

  assign mid      = prescale >> 1;
  assign last     = prescale - PRESCALE_W'(1);
  assign bit_done = run && (edge_count == last);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_count     <= '0;
      bit_count      <= '0;
      early          <= '0;
      decision       <= 1'b0;
      decision_valid <= 1'b0;
    end else if (!run) begin
      edge_count     <= '0;
      bit_count      <= '0;
      decision_valid <= 1'b0;
    end else begin
      decision_valid <= 1'b0;
      if (bit_done) begin
        edge_count <= '0;
        bit_count  <= bit_count + 4'd1;
      end else begin
        edge_count <= edge_count + PRESCALE_W'(1);
      end
      if (edge_count == mid - PRESCALE_W'(VOTE_OFFSET)) early[0] <= rx;
      if (edge_count == mid) early[1] <= rx;
      if (edge_count == mid + PRESCALE_W'(VOTE_OFFSET)) begin
        decision       <= (early[0] & early[1]) | (early[0] & rx) | (early[1] & rx);
        decision_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: frame FSM, parity/stop checking and a
// handshaked holding register. Define UART_RX_BREAK_DETECT_EN to add break_detect.
module uart_rx_cfg
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk_based_on_prescale,
  input  logic                  asy_reset,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  parity_enable,
  input  logic                  parity_type,
  input  logic                  two_stop,
  input  logic                  data_ready,
  output logic [DATA_WIDTH-1:0] parallel_data,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  framing_error,
`ifdef UART_RX_BREAK_DETECT_EN
  output logic                  break_detect,
`endif
  output logic                  overrun_error
);

  rx_state_t             state, state_next;
  logic                  line_wait, line_wait_next;
  frame_cfg_t            cfg;
  logic [PRESCALE_W-1:0] prescale_q;
  logic                  rx_q;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  parity_bad;
  logic [3:0]            bit_count;
  logic                  bit_done, decision, decision_valid;
  logic                  start, shift_en, parity_check, stop_good, stop_bad;
  logic                  is_break, frame_ok, err_parity, err_frame;

  uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
    .clk            (clk_based_on_prescale),
    .rst_n          (asy_reset),
    .rx             (RX_IN),
    .run            (state != IDLE),
    .prescale       (prescale_q),
    .bit_count      (bit_count),
    .bit_done       (bit_done),
    .decision       (decision),
    .decision_valid (decision_valid)
  );

  always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
    if (!asy_reset) begin
      state     <= IDLE;
      line_wait <= 1'b0;
    end else begin
      state     <= state_next;
      line_wait <= line_wait_next;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next     = state;
    line_wait_next = line_wait;
    start          = 1'b0;
    shift_en       = 1'b0;
    parity_check   = 1'b0;
    stop_good      = 1'b0;
    stop_bad       = 1'b0;
    case (state)
      IDLE: begin
        // rx_q gates the start so a line held low through reset is ignored.
        if (rx_q && !RX_IN) begin
          state_next = START;
          start      = 1'b1;
        end
      end
      START: begin
        if (decision_valid && decision) state_next = IDLE;
        else if (bit_done)              state_next = DATA;
      end
      DATA: begin
        shift_en = decision_valid;
        if (bit_done && bit_count == 4'(DATA_WIDTH))
          state_next = cfg.parity_enable ? PARITY : STOP1;
      end
      PARITY: begin
        parity_check = decision_valid;
        if (bit_done) state_next = STOP1;
      end
      STOP1, STOP2: begin
        if (line_wait) begin
          if (RX_IN) begin
            state_next     = IDLE;
            line_wait_next = 1'b0;
          end
        end else if (decision_valid) begin
          if (!decision) begin
            stop_bad       = 1'b1;
            line_wait_next = 1'b1;
          end else if (state == STOP2 || !cfg.two_stop) begin
            stop_good  = 1'b1;
            state_next = IDLE;
          end
        end else if (bit_done && state == STOP1 && cfg.two_stop) begin
          state_next = STOP2;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef UART_RX_BREAK_DETECT_EN
  logic all_zero;
  assign is_break = stop_bad && (state == STOP1) && all_zero;
`else
  assign is_break = 1'b0;
`endif

  assign frame_ok   = stop_good && !parity_bad;
  assign err_parity = (stop_good || stop_bad) && parity_bad && !is_break;
  assign err_frame  = stop_bad && !parity_bad && !is_break;

  always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
    if (!asy_reset) begin
      cfg           <= '0;
      prescale_q    <= '0;
      rx_q          <= 1'b0;
      shreg         <= '0;
      parity_bad    <= 1'b0;
      parallel_data <= '0;
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      all_zero      <= 1'b0;
      break_detect  <= 1'b0;
`endif
    end else begin
      rx_q          <= RX_IN;
      parity_error  <= err_parity;
      framing_error <= err_frame;
      overrun_error <= frame_ok && data_valid && !data_ready;
`ifdef UART_RX_BREAK_DETECT_EN
      break_detect  <= is_break;
      if (start)                   all_zero <= 1'b1;
      if (shift_en || parity_check) all_zero <= all_zero & ~decision;
`endif
      if (start) begin
        cfg        <= '{parity_enable: parity_enable, parity_type: parity_type, two_stop: two_stop};
        prescale_q <= prescale_is_legal(32'(prescale)) ? prescale : PRESCALE_W'(PRESCALE_16);
        parity_bad <= 1'b0;
      end
      if (shift_en) shreg <= {decision, shreg[DATA_WIDTH-1:1]};
      // Expected parity bit is the data XOR, inverted for odd parity.
      if (parity_check) parity_bad <= decision ^ (^shreg) ^ cfg.parity_type;
      if (frame_ok && (!data_valid || data_ready)) begin
        parallel_data <= shreg;
        data_valid    <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule
